// File: rtl/down_counter_ctrl.sv
// Loadable down-counter with a variable per-cycle decrement. It pulses done when the
// budget is exhausted and flags an underflow when the final step overshot zero.
module down_counter_ctrl #(
  parameter int WIDTH      = 32,
  parameter int STEP_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  enable,
  input  logic [STEP_WIDTH-1:0] decrement,
  input  logic                  abort,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  done,
  output logic                  underflow
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             underflow_q, underflow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step;

  assign step = {{(WIDTH-STEP_WIDTH){1'b0}}, decrement};

  // NOTE: every always_comb target gets a default first so that no latch is inferred.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    underflow_d = underflow_q;

    if (abort) begin
      state_d     = ST_IDLE;
      count_d     = '0;
      underflow_d = 1'b0;
    end else if (load) begin
      state_d     = ST_RUN;
      count_d     = load_value;
      underflow_d = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (enable) begin
            // A count already at zero terminates cleanly; it cannot overshoot.
            if (count_q <= step) begin
              count_d     = '0;
              underflow_d = (count_q != '0) && (count_q < step);
              state_d     = ST_DONE;
            end else begin
              count_d = count_q - step;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        ST_IDLE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // NOTE: state flops use non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      underflow_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign count     = count_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_down_counter_ctrl.sv
// Directed bench for down_counter_ctrl. Each expected value is hand-computed from the budget
// and step sequence applied.
module tb_down_counter_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] load_value;
  logic        enable;
  logic [8:0]  decrement;
  logic        abort;
  logic [31:0] count;
  logic        busy, done, underflow;

  int checks = 0;
  int errors = 0;

  down_counter_ctrl #(.WIDTH(32), .STEP_WIDTH(9)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_value (load_value),
    .enable     (enable),
    .decrement  (decrement),
    .abort      (abort),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] c, input logic b,
                           input logic d, input logic u);
    check({tag, ".count"}, count, c);
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    check({tag, ".done"}, {31'd0, done}, {31'd0, d});
    check({tag, ".uf"}, {31'd0, underflow}, {31'd0, u});
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_value = '0; enable = 1'b0; decrement = '0; abort = 1'b0;
    #12;
    rst = 1'b0;
    #1;
    check_all("reset", 0, 0, 0, 0);

    // Exact exhaustion: 9 -> 6 -> 3 -> 0
    load = 1'b1; load_value = 9; decrement = 3; enable = 1'b1;
    step(); check_all("t1.load", 9, 1, 0, 0);
    load = 1'b0;
    step(); check_all("t1.6", 6, 1, 0, 0);
    step(); check_all("t1.3", 3, 1, 0, 0);
    step(); check_all("t1.done", 0, 0, 1, 0);
    step(); check_all("t1.idle", 0, 0, 0, 0);

    // Overshoot: 10 -> 7 -> 4 -> 1 -> 0 with underflow
    load = 1'b1; load_value = 10;
    step(); check_all("t2.load", 10, 1, 0, 0);
    load = 1'b0;
    step(); check("t2.7", count, 7);
    step(); check("t2.4", count, 4);
    step(); check("t2.1", count, 1);
    step(); check_all("t2.done", 0, 0, 1, 1);
    step(); check_all("t2.sticky", 0, 0, 0, 1);

    // Enable gaps and a zero step
    load = 1'b1; load_value = 8; decrement = 2;
    step(); check_all("t3.load", 8, 1, 0, 0);
    load = 1'b0;
    step(); check("t3.6", count, 6);
    enable = 1'b0;
    step(); check("t3.hold1", count, 6);
    step(); check("t3.hold2", count, 6);
    enable = 1'b1; decrement = 0;
    step(); check_all("t3.dec0", 6, 1, 0, 0);
    decrement = 2;
    step(); check("t3.4", count, 4);
    step(); check("t3.2", count, 2);
    step(); check_all("t3.done", 0, 0, 1, 0);

    // Abort after three decrements
    load = 1'b1; load_value = 100; decrement = 5;
    step(); check("t4.load", count, 100);
    load = 1'b0;
    step(); check("t4.95", count, 95);
    step(); check("t4.90", count, 90);
    step(); check("t4.85", count, 85);
    abort = 1'b1;
    step(); check_all("t4.abort", 0, 0, 0, 0);
    abort = 1'b0;
    step(); check_all("t4.idle", 0, 0, 0, 0);

    // Restart in RUN, then zero budget
    load = 1'b1; load_value = 14; decrement = 3;
    step(); check("t5.14", count, 14);
    load = 1'b0;
    step(); check("t5.11", count, 11);
    load = 1'b1; load_value = 20;
    step(); check_all("t5.reload", 20, 1, 0, 0);
    load_value = 0; enable = 1'b0;
    step(); check_all("t5.zero", 0, 1, 0, 0);
    load = 1'b0; enable = 1'b1;
    step(); check_all("t5.zdone", 0, 0, 1, 0);

    // Load while in DONE
    load = 1'b1; load_value = 4; decrement = 4;
    step(); check("t6.4", count, 4);
    load = 1'b0;
    step(); check_all("t6.done", 0, 0, 1, 0);
    load = 1'b1; load_value = 7;
    step(); check_all("t6.reload", 7, 1, 0, 0);
    load = 1'b0; enable = 1'b0;

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1 check_all("t6.rst", 0, 0, 0, 0);
    #1 rst = 1'b0;
    step(); check_all("t6.postrst", 0, 0, 0, 0);

    // abort wins over load
    load = 1'b1; load_value = 5;
    step(); check("t6.5", count, 5);
    abort = 1'b1; load_value = 9;
    step(); check_all("t6.abortwins", 0, 0, 0, 0);
    abort = 1'b0; load = 1'b0;
    step(); check_all("t6.idle", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
